// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshakes and UART TX byte stream of the response scheduler.
interface uart_tx_sched_if;
    logic        nonce_req, nonce_ack, loop_req, loop_ack;
    logic [31:0] nonce;
    logic [7:0]  loop_byte, tx_data;
    logic        new_tx_data, tx_busy, busy;
    modport master (
        output nonce_req, nonce, loop_req, loop_byte, tx_busy,
        input  nonce_ack, loop_ack, tx_data, new_tx_data, busy
    );
    modport slave (
        input  nonce_req, nonce, loop_req, loop_byte, tx_busy,
        output nonce_ack, loop_ack, tx_data, new_tx_data, busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: frames nonce and loop-echo responses into a UART TX byte stream.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration; otherwise nonce has strict priority.
module uart_tx_sched (
    input  logic clk,
    input  logic rst,
    uart_tx_sched_if.slave bus
);
    localparam logic [7:0] HDR_BYTE  = 8'h55;
    localparam logic [7:0] NONCE_CMD = 8'h00;
    localparam logic [7:0] LOOP_CMD  = 8'h01;
    typedef enum logic [2:0] {IDLE, HDR, CMD, LEN, DATA, GAP, DONE} state_t;
    state_t      state, state_n, nxt, nxt_n;
    logic        sel, sel_n, pick, emit;
    logic [31:0] pay, pay_n;
    logic [2:0]  cnt, cnt_n;
    logic [7:0]  byte_n;
`ifdef UART_TX_SCHED_RR_EN
    logic ptr;
    assign pick = ptr ? bus.loop_req : !bus.nonce_req;
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (state == IDLE && (bus.nonce_req || bus.loop_req)) ptr <= !pick;
`else
    assign pick = !bus.nonce_req;
`endif
    // Strobe is decided one cycle ahead so the registered strobe lands on entry to a byte state.
    always_comb begin
        state_n = state;
        nxt_n   = nxt;
        sel_n   = sel;
        pay_n   = pay;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.nonce_req || bus.loop_req) begin
                state_n = HDR;
                sel_n   = pick;
                pay_n   = pick ? {24'h0, bus.loop_byte} : bus.nonce;
                cnt_n   = pick ? 3'd1 : 3'd4;
            end
            HDR, CMD, LEN, DATA: if (bus.new_tx_data) begin
                state_n = (state == DATA && cnt == 3'd1) ? DONE : GAP;
                nxt_n   = state == HDR ? CMD : state == CMD ? LEN : DATA;
                if (state == DATA) begin
                    pay_n = pay >> 8;
                    cnt_n = cnt - 3'd1;
                end
            end
            GAP: state_n = nxt;
            default: state_n = IDLE;
        endcase
        emit   = (state_n inside {HDR, CMD, LEN, DATA}) && !bus.tx_busy;
        byte_n = state_n == HDR ? HDR_BYTE :
                 state_n == CMD ? (sel_n ? LOOP_CMD : NONCE_CMD) :
                 state_n == LEN ? (sel_n ? 8'h01 : 8'h04) : pay_n[7:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            nxt             <= IDLE;
            sel             <= 1'b0;
            pay             <= '0;
            cnt             <= '0;
            bus.tx_data     <= 8'h00;
            bus.new_tx_data <= 1'b0;
            bus.nonce_ack   <= 1'b0;
            bus.loop_ack    <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            nxt             <= nxt_n;
            sel             <= sel_n;
            pay             <= pay_n;
            cnt             <= cnt_n;
            bus.new_tx_data <= emit;
            if (emit) bus.tx_data <= byte_n;
            bus.nonce_ack   <= state_n == DONE && !sel;
            bus.loop_ack    <= state_n == DONE && sel;
            bus.busy        <= state_n != IDLE;
        end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench; expected frames come from a byte-list model.
module tb_uart_tx_sched;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    uart_tx_sched_if bus();
    uart_tx_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int n_cmp = 0, n_bad = 0, n_strobe = 0, n_ack = 0;
    int busy_len = 1, bcnt = 0;
    logic force_busy = 1'b0, prev_strobe = 1'b0;
    logic [7:0] exp_q[$];
    bit ack_q[$];
    // UART model: busy for busy_len cycles starting the cycle after each strobe
    assign bus.tx_busy = force_busy || bcnt != 0;
    always @(posedge clk or posedge rst)
        if (rst) bcnt <= 0;
        else if (bus.new_tx_data) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic push_frame(bit is_loop, logic [31:0] v);
        int len = is_loop ? 1 : 4;
        exp_q.push_back(8'h55);
        exp_q.push_back(is_loop ? 8'h01 : 8'h00);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) exp_q.push_back(8'(v >> (8 * i)));
        ack_q.push_back(is_loop);
    endtask
    always @(negedge clk)
        if (rst) prev_strobe = 1'b0;
        else begin
            if (bus.new_tx_data) begin
                n_strobe++;
                check("strobe_not_adjacent", prev_strobe, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_byte: got %h expected none", bus.tx_data);
                end else check("tx_byte", bus.tx_data, exp_q.pop_front());
            end
            if (bus.nonce_ack || bus.loop_ack) begin
                n_ack++;
                if (ack_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_ack: got %b%b expected none", bus.loop_ack, bus.nonce_ack);
                end else check("ack_kind", {bus.loop_ack, bus.nonce_ack}, ack_q.pop_front() ? 2'b10 : 2'b01);
            end
            prev_strobe = bus.new_tx_data;
        end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_acks(int target, int limit);
        int t = 0;
        while (n_ack < target && t < limit) begin tick(); t++; end
        check("ack_timeout", n_ack >= target, 1);
    endtask
    task automatic wait_strobes(int target, int limit);
        int t = 0;
        while (n_strobe < target && t < limit) begin tick(); t++; end
        check("strobe_timeout", n_strobe >= target, 1);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.nonce_req = 1'b0;
        bus.loop_req = 1'b0;
        exp_q.delete();
        ack_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask
    task automatic run_frame(bit is_loop, logic [31:0] v, bit meddle);
        int a = n_ack, s = n_strobe;
        push_frame(is_loop, v);
        if (is_loop) begin bus.loop_byte = v[7:0]; bus.loop_req = 1'b1; end
        else begin bus.nonce = v; bus.nonce_req = 1'b1; end
        if (meddle) begin
            wait_strobes(s + 1, 200);
            bus.nonce_req = 1'b0;
            bus.nonce = $urandom;
            bus.loop_byte = 8'($urandom);
        end
        wait_acks(a + 1, 1000);
        bus.nonce_req = 1'b0;
        bus.loop_req = 1'b0;
        check("frame_drained", exp_q.size(), 0);
    endtask
    initial begin
        int a, s;
        bus.nonce_req = 1'b0; bus.loop_req = 1'b0; bus.nonce = '0; bus.loop_byte = '0;
        #1 rst = 1'b1;
        #1 check("reset_outputs", {bus.new_tx_data, bus.nonce_ack, bus.loop_ack, bus.busy, bus.tx_data}, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        busy_len = 10;
        push_frame(0, 32'h12345678);
        bus.nonce = 32'h12345678;
        bus.nonce_req = 1'b1;
        a = n_ack;
        tick();
        check("hdr_latency", {bus.new_tx_data, bus.tx_data}, {1'b1, 8'h55});
        wait_acks(a + 1, 1000);
        bus.nonce_req = 1'b0;
        busy_len = 3;
        run_frame(1, 32'hA5, 0);
        repeat (2) tick();
        check("busy_low_after", bus.busy, 0);
        force_busy = 1'b1;
        s = n_strobe;
        a = n_ack;
        push_frame(1, 32'h3C);
        bus.loop_byte = 8'h3C;
        bus.loop_req = 1'b1;
        repeat (50) tick();
        check("stall_no_strobe", n_strobe - s, 0);
        check("stall_busy", bus.busy, 1);
        force_busy = 1'b0;
        wait_acks(a + 1, 500);
        bus.loop_req = 1'b0;
        busy_len = 2;
        run_frame(0, 32'hCAFEF00D, 1);
        tick();
        s = n_strobe;
        push_frame(0, 32'hDEADBEEF);
        bus.nonce = 32'hDEADBEEF;
        bus.nonce_req = 1'b1;
        wait_strobes(s + 3, 200);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {bus.new_tx_data, bus.nonce_ack, bus.loop_ack, bus.busy, bus.tx_data}, 0);
        bus.nonce_req = 1'b0;
        exp_q.delete();
        ack_q.delete();
        tick();
        rst = 1'b0;
        tick();
        run_frame(1, 32'h77, 0);
        do_reset();
        busy_len = 1;
        a = n_ack;
        for (int i = 0; i < 4; i++)
`ifdef UART_TX_SCHED_RR_EN
            push_frame(i % 2 == 1, (i % 2 == 1) ? 32'h9A : 32'h11223344);
`else
            push_frame(0, 32'h11223344);
`endif
        bus.nonce = 32'h11223344;
        bus.loop_byte = 8'h9A;
        bus.nonce_req = 1'b1;
        bus.loop_req = 1'b1;
        wait_acks(a + 4, 2000);
        bus.nonce_req = 1'b0;
        bus.loop_req = 1'b0;
        repeat (3) tick();
        check("arb_frames_drained", exp_q.size() + ack_q.size(), 0);
        for (int i = 0; i < 20; i++) begin
            bit lp = 1'($urandom);
            busy_len = $urandom_range(1, 6);
            run_frame(lp, lp ? {24'h0, 8'($urandom)} : $urandom, 1'($urandom));
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (3) tick();
        check("final_busy", bus.busy, 0);
        check("queues_drained", exp_q.size() + ack_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
